// File: rtl/signmag_decode_if.sv
// rtl/signmag_decode_if.sv - input/output stream bundle for signmag_decode
interface signmag_decode_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         out_sat;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sat
    );
endinterface

// File: rtl/signmag_decode.sv
// rtl/signmag_decode.sv - two's-complement to sign-magnitude stream converter with 2-entry output FIFO
// Optional saturation event counter enabled by defining SIGNMAG_SATCNT_EN.
module signmag_decode #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    signmag_decode_if.slave  bus,
    input  logic             sat_cnt_clr,
    output logic [7:0]       sat_cnt
);
    typedef struct packed {
        logic         last;
        logic         sat;
        logic [W-1:0] data;
    } entry_t;

    // The most-negative input has no sign-magnitude encoding; it clamps to -(2^(W-1)-1).
    function automatic entry_t convert(input logic [W-1:0] x, input logic last);
        entry_t       e;
        logic [W-1:0] neg;
        neg    = ~x + 1'b1;
        e.last = last;
        e.sat  = 1'b0;
        if (!x[W-1]) begin
            e.data = x;
        end else if (x[W-2:0] == '0) begin
            e.data = '1;
            e.sat  = 1'b1;
        end else begin
            e.data = {1'b1, neg[W-2:0]};
        end
        return e;
    endfunction

    entry_t     head_q, tail_q, head_n, tail_n, incoming;
    logic [1:0] count_q, count_n;
    logic       in_ready_q, out_valid_q;
    logic       push, pop;

    assign incoming = convert(bus.in_data, bus.in_last);
    assign push     = bus.in_valid && in_ready_q;
    assign pop      = out_valid_q && bus.out_ready;

    // Entries are cleared when vacated so the head reads as zero while empty.
    always_comb begin
        head_n  = head_q;
        tail_n  = tail_q;
        count_n = count_q;
        if (push && pop) begin
            head_n = incoming;
        end else if (push) begin
            if (count_q == 2'd0) head_n = incoming;
            else                 tail_n = incoming;
            count_n = count_q + 2'd1;
        end else if (pop) begin
            head_n  = tail_q;
            tail_n  = '0;
            count_n = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= 2'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            head_q      <= head_n;
            tail_q      <= tail_n;
            count_q     <= count_n;
            in_ready_q  <= (count_n != 2'd2);
            out_valid_q <= (count_n != 2'd0);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = head_q.data;
    assign bus.out_last  = head_q.last;
    assign bus.out_sat   = head_q.sat;

`ifdef SIGNMAG_SATCNT_EN
    logic [7:0] sat_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || sat_cnt_clr) begin
            sat_cnt_q <= 8'd0;
        end else if (pop && head_q.sat && sat_cnt_q != 8'hFF) begin
            sat_cnt_q <= sat_cnt_q + 8'd1;
        end
    end

    assign sat_cnt = sat_cnt_q;
`else
    logic unused_sat_cnt_clr;
    assign unused_sat_cnt_clr = sat_cnt_clr;
    assign sat_cnt            = 8'd0;
`endif
endmodule

// File: doc/signmag_decode.md
# signmag_decode

Streaming two's-complement to sign-magnitude converter for the PE output path. Pixel results and partial sums leave the weight-stationary PE array in two's complement. This block converts them back to the sign-magnitude format used by the off-array buffers, which is the inverse of the sign-magnitude to two's-complement step on the weight-load side. It has a valid/ready handshake, a 2-entry registered output FIFO, end-of-frame passthrough, and handling for the one unrepresentable value.

## Interface
- W, 8, data width in bits (sign bit plus W-1 magnitude bits); legal range 4..16
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  block can accept a word; registered
- in_data  in  W  two's-complement input word
- in_last  in  1  last word of frame; sideband
- out_valid  out  1  output word valid; registered
- out_ready  in  1  downstream accepts
- out_data  out  W  sign-magnitude word: bit W-1 is the sign, bits W-2:0 are the magnitude
- out_last  out  1  in_last of the same word
- out_sat  out  1  word was the most-negative input and has been clamped
- sat_cnt_clr  in  1  clear the saturation counter
- sat_cnt  out  8  saturation event count (see Configuration)

## Operation
- Input handshake: a word is accepted when in_valid && in_ready.
- Output handshake: a word is accepted when out_valid && out_ready.
- Conversion happens before storage. Each FIFO entry holds {last, sat, data}.
  - x[W-1]==0: data = x, sat = 0.
  - x == 1 followed by W-1 zeros (e.g. 0x80 for W=8): data = all ones (0xFF = -127), sat = 1.
  - otherwise: data = {1'b1, (~x + 1)[W-2:0]}, sat = 0.
  - A -0 encoding (0x80) is never produced.
- FIFO depth is 2, occupancy count 0..2, in-order.
- Outputs out_valid, out_data, out_last and out_sat always come from the head entry.
- Push and pop in the same cycle at count==1: count stays 1 and the head is replaced by the incoming word.
- Push and pop in the same cycle at count==0: not possible, because out_valid is 0.
- Full (count==2): in_ready = 0, and in_valid is ignored.
- Empty: out_valid = 0; out_data, out_last and out_sat are 0.
- in_ready_next = (count_next != 2). No combinational path from out_ready or in_valid to in_ready.
- A word on in_data while in_valid is low is ignored, whatever its value.

## Timing
- Reset (rst_n low at a clock edge):
  - count = 0, out_valid = 0, out_data = 0, out_last = 0, out_sat = 0, in_ready = 0, sat_cnt = 0.
  - While rst_n is low, in_ready stays 0 and the FIFO is held empty.
  - in_ready rises to 1 at the first edge with rst_n high.
- Reset mid-stream: all stored words are discarded, with no partial output. A word presented during reset is never accepted.
- Latency: a word accepted at edge N into an empty FIFO gives out_valid = 1 after edge N.
- Throughput: 1 word/cycle while out_ready is held high.
- Backpressure: a stalled output holds out_data, out_last and out_sat stable until it is accepted.
- Full-to-accept recovery: when the head pops at edge N from full, in_ready = 1 after edge N.

## Configuration
- SIGNMAG_SATCNT_EN defined:
  - sat_cnt increments on each output handshake with out_sat = 1, saturating at 255.
  - sat_cnt_clr clears it at the next edge and has priority over a simultaneous increment.
- Not defined:
  - The counter logic is removed.
  - sat_cnt is tied to 0 and sat_cnt_clr is ignored.
  - Data path behaviour is identical in both builds.

## Test plan
- W=8, out_ready=1; stream 0x05, 0xFB, 0x7F, 0x81, 0x00 -> out 0x05, 0x85, 0x7F, 0xFF, 0x00, all with out_sat = 0, one per cycle, each 1 cycle after its input.
- Input 0x80 with in_last=1 -> out_data=0xFF, out_sat=1, out_last=1. With the macro, sat_cnt goes 0->1 after the handshake.
- out_ready=0 and push 3 words -> in_ready falls after the 2nd accept and the 3rd word waits. Raise out_ready -> words come out in order with no loss or duplication, and in_ready returns 1 one cycle after the first pop.
- FIFO holds 1 word; apply push and pop in the same cycle with 0x01 then 0xFF -> count stays 1, and next out_data = 0x81.
- Assert rst_n=0 for 1 cycle with 2 words stored -> out_valid=0 and in_ready=0 during reset, in_ready=1 the cycle after, and no stored word ever appears.
- Macro builds, with 256 inputs of 0x80:
  - defined: sat_cnt holds at 255; sat_cnt_clr asserted together with a saturating pop gives sat_cnt = 0.
  - undefined: sat_cnt stays 0 throughout.
